// File: rtl/alu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_pkg : op codes, FSM state type and data width shared by the ALU blocks |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] ALU_ADD_S = 3'b000;
    localparam logic [2:0] ALU_ADD_U = 3'b001;
    localparam logic [2:0] ALU_SUB_S = 3'b010;
    localparam logic [2:0] ALU_SUB_U = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SRA   = 3'b110;
    localparam logic [2:0] ALU_SRL   = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu : combinational 32-bit add/sub/logic/shift unit                        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  logic [2:0]       i_sel,
    output logic [ALU_W-1:0] o_y
);

    // Shift amounts of 32 or more saturate to the fully shifted-out value.
    logic w_big_shift;
    assign w_big_shift = |i_b[ALU_W-1:5];

    always_comb begin
        o_y = '0;
        case (i_sel)
            ALU_ADD_S, ALU_ADD_U: o_y = i_a + i_b;
            ALU_SUB_S, ALU_SUB_U: o_y = i_a - i_b;
            ALU_AND:              o_y = i_a & i_b;
            ALU_OR:               o_y = i_a | i_b;
            ALU_SRA:              o_y = w_big_shift ? {ALU_W{i_a[ALU_W-1]}}
                                                    : ALU_W'($signed(i_a) >>> i_b[4:0]);
            ALU_SRL:              o_y = w_big_shift ? '0 : (i_a >> i_b[4:0]);
            default:              o_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_arbiter : two-requester arbiter time-sharing one alu instance          |
// | Option macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins (no prio reg)  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [2:0]  req_sel0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [2:0]  req_sel1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data
);

    arb_state_t       state_q, state_d;
    logic [ALU_W-1:0] res_q, res_d;
    logic             owner_q, owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             prio_q, prio_d;
`endif

    logic             w_grant;
    logic             w_accept;
    logic [ALU_W-1:0] w_alu_a, w_alu_b, w_alu_y;
    logic [2:0]       w_alu_sel;

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_grant = ~req_valid[0];
`else
        // A lone requester wins outright; prio only breaks a tie.
        w_grant = (req_valid == 2'b11) ? prio_q : req_valid[1];
`endif
        req_ready = 2'b00;
        if (state_q == IDLE && req_valid[w_grant]) begin
            req_ready[w_grant] = 1'b1;
        end
        w_accept  = |(req_valid & req_ready);
        w_alu_a   = w_grant ? req_a1   : req_a0;
        w_alu_b   = w_grant ? req_b1   : req_b0;
        w_alu_sel = w_grant ? req_sel1 : req_sel0;
    end

    alu u_alu (
        .i_a   (w_alu_a),
        .i_b   (w_alu_b),
        .i_sel (w_alu_sel),
        .o_y   (w_alu_y)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        owner_d = owner_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = RESP;
                    res_d   = w_alu_y;
                    owner_d = w_grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    prio_d  = ~w_grant;
`endif
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            owner_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            owner_q <= owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio_q  <= prio_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = res_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_alu_arbiter : scoreboard bench for alu_arbiter                          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]  req_sel0, req_sel1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_prev_v = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_sel0  (req_sel0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_sel1  (req_sel1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: a fresh response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid != 2'b00 && !mon_prev_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b, expected none", rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_owner", {30'd0, rsp_valid}, mon_e.owner ? 32'd2 : 32'd1);
                check("rsp_data", rsp_data, mon_e.data);
            end
        end
        mon_prev_v = (rsp_valid != 2'b00);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_op(input logic who, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] sel, input logic [31:0] y, input string name);
        if (who) begin
            req_a1 = a; req_b1 = b; req_sel1 = sel;
        end else begin
            req_a0 = a; req_b0 = b; req_sel0 = sel;
        end
        req_valid = who ? 2'b10 : 2'b01;
        rsp_ready = 2'b11;
        #1;
        check({name, "_req_ready"}, {30'd0, req_ready}, who ? 32'd2 : 32'd1);
        exp_q.push_back({who, y});
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 2'b00;
    endtask

    logic [1:0] grant_pat [8];

    initial begin
        req_a0 = '0; req_b0 = '0; req_sel0 = '0;
        req_a1 = '0; req_b1 = '0; req_sel1 = '0;
        do_reset();

        // Reset state
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        req_valid = 2'b11;
        #1;
        check("reset_tie_grant", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;

        // Single op with held response
        req_a0 = 32'd5; req_b0 = 32'd7; req_sel0 = 3'b000;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        #1;
        check("t1_req_ready", {30'd0, req_ready}, 32'd1);
        exp_q.push_back({1'b0, 32'd12});
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            check("t1_hold_data", rsp_data, 32'd12);
            check("t1_hold_valid", {30'd0, rsp_valid}, 32'd1);
            check("t1_busy_ready", {30'd0, req_ready}, 32'd0);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        check("t1_consumed", {30'd0, rsp_valid}, 32'd0);
        rsp_ready = 2'b00;

        // Contention: round robin (or fixed priority in that build)
        do_reset();
        req_a0 = 32'd1;  req_b0 = 32'd2; req_sel0 = 3'b000;
        req_a1 = 32'd10; req_b1 = 32'd3; req_sel1 = 3'b010;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant_pat = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'd3});
`else
        grant_pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        exp_q.push_back({1'b0, 32'd3});
        exp_q.push_back({1'b1, 32'd7});
        exp_q.push_back({1'b0, 32'd3});
        exp_q.push_back({1'b1, 32'd7});
`endif
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("t2_grant_seq", {30'd0, req_ready}, {30'd0, grant_pat[i]});
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();

        // Shifts
        run_op(1'b0, 32'h8000_0000, 32'd4,  3'b110, 32'hF800_0000, "sra4");
        run_op(1'b1, 32'h8000_0000, 32'd4,  3'b111, 32'h0800_0000, "srl4");
        run_op(1'b0, 32'h8000_0000, 32'd40, 3'b110, 32'hFFFF_FFFF, "sra40");
        run_op(1'b1, 32'h8000_0000, 32'd40, 3'b111, 32'h0000_0000, "srl40");

        // Arithmetic wrap and logic ops
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b001, 32'h0000_0000, "addu_wrap");
        run_op(1'b1, 32'h0000_0000, 32'd1, 3'b011, 32'hFFFF_FFFF, "subu_wrap");
        run_op(1'b1, 32'd3,         32'd5, 3'b010, 32'hFFFF_FFFE, "subs_neg");
        run_op(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'hF000_F000, "and");
        run_op(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'hFFF0_FFF0, "or");

        // Reset during RESP discards the result
        req_a1 = 32'd3; req_b1 = 32'd5; req_sel1 = 3'b000;
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        check("t5_req_ready", {30'd0, req_ready}, 32'd2);
        exp_q.push_back({1'b1, 32'd8});
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", {30'd0, rsp_valid}, 32'd0);
        check("t5_rst_data", rsp_data, 32'd0);
        req_a0 = 32'd2; req_b0 = 32'd2; req_sel0 = 3'b000;
        req_valid = 2'b11;
        #1;
        check("t5_post_grant", {30'd0, req_ready}, 32'd1);
        exp_q.push_back({1'b0, 32'd4});
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;

        // Reset coinciding with an accept: nothing is captured
        req_a0 = 32'd9; req_b0 = 32'd9; req_sel0 = 3'b000;
        req_valid = 2'b01;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 2'b00;
        check("rst_accept_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_accept_data", rsp_data, 32'd0);
        tick();
        check("rst_accept_idle", {30'd0, rsp_valid}, 32'd0);

        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
